// File: rtl/capture_scheduler.sv
// capture_scheduler: collects sw/periodic triggers for two cameras and sequences captures
// through one shared slot with round-robin arbitration, timeout and timed cam reset.
module capture_scheduler #(
    parameter int PRESCALE       = 1000,
    parameter int TIMEOUT_CYCLES = 4000000,
    parameter int RST_CYCLES     = 16,
    parameter int GAP_CYCLES     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  cam_enable,
    input  logic [1:0]  sw_trigger,
    input  logic [15:0] period0,
    input  logic [15:0] period1,
    input  logic [1:0]  fifo_afull,
    input  logic [1:0]  frame_capture_done,
    input  logic        clear_err,
    output logic [1:0]  frame_capture_start,
    output logic [1:0]  cam_reset,
    output logic        busy,
    output logic        active_cam,
    output logic [1:0]  pending,
    output logic [1:0]  overrun,
    output logic [1:0]  timeout_err,
    output logic [15:0] frame_count0,
    output logic [15:0] frame_count1
);
    localparam int PW = $clog2(PRESCALE);
    localparam int CW = $clog2(TIMEOUT_CYCLES + RST_CYCLES + GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, RESET, GAP} state_t;

    state_t             state;
    logic [PW-1:0]      pre;
    logic [CW-1:0]      cnt;
    logic               rr;
    logic               tick;
    logic               pick;
    logic [1:0]         on;
    logic [1:0]         periodic;
    logic [1:0]         req;
    logic [1:0]         clr;
    logic [1:0]         elig;
    logic [1:0][15:0]   period;

    assign period = {period1, period0};
    assign tick   = pre == PW'(PRESCALE - 1);
    assign on     = {2{enable}} & cam_enable;
    assign req    = (sw_trigger | periodic) & on;
    assign clr    = (state == START) ? (active_cam ? 2'b10 : 2'b01) : 2'b00;
    assign elig   = pending & ~fifo_afull;
    // rr holds the preferred camera for a tie; it flips away from whoever was just served
    assign pick   = (elig == 2'b11) ? rr : elig[1];

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) pre <= '0;
        else pre <= tick ? '0 : pre + 1'b1;

    for (genvar i = 0; i < 2; i++) begin : g_per
        logic [15:0] pc;
        logic        on_p;
        assign on_p        = on[i] && period[i] != 16'd0;
        assign periodic[i] = on_p && tick && pc == period[i] - 16'd1;
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) pc <= '0;
            else pc <= (!on_p || periodic[i]) ? '0 : pc + {15'd0, tick};
    end

    // a request landing in the START cycle re-arms pending without counting as an overrun
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= on & (req | (pending & ~clr));
            overrun <= (req & pending & ~clr) | (clear_err ? 2'b00 : overrun);
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            rr                  <= 1'b0;
            active_cam          <= 1'b0;
            busy                <= 1'b0;
            frame_capture_start <= '0;
            cam_reset           <= '0;
            timeout_err         <= '0;
            frame_count0        <= '0;
            frame_count1        <= '0;
        end else begin
            timeout_err <= clear_err ? 2'b00 : timeout_err;
            case (state)
                IDLE: if (|elig) begin
                    active_cam          <= pick;
                    rr                  <= ~pick;
                    frame_capture_start <= pick ? 2'b10 : 2'b01;
                    busy                <= 1'b1;
                    state               <= START;
                end
                START: begin
                    frame_capture_start <= '0;
                    cnt                 <= '0;
                    state               <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (frame_capture_done[active_cam]) begin
                        if (active_cam) frame_count1 <= frame_count1 + 16'd1;
                        else frame_count0 <= frame_count0 + 16'd1;
                        cnt   <= '0;
                        state <= GAP;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err[active_cam] <= 1'b1;
                        cam_reset[active_cam]   <= 1'b1;
                        cnt                     <= '0;
                        state                   <= RESET;
                    end
                end
                RESET: if (cnt == CW'(RST_CYCLES - 1)) begin
                    cam_reset <= '0;
                    cnt       <= '0;
                    state     <= GAP;
                end else cnt <= cnt + 1'b1;
                GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/capture_scheduler.md
Name: capture_scheduler

Overview:
- Sequences frame captures for two Stonyman camera pipelines (cam0, cam1) that share one capture slot.
- Collects software triggers and periodic triggers per camera, then arbitrates round-robin among them.
- Issues frame_capture_start pulses and watches for frame_capture_done. On a hung capture it issues a timed cam reset.
- Sits between the imager APB register block and the per-camera stonyman/adc/fifo datapaths.

Parameters:
PRESCALE, 1000, clk cycles per period tick (>=2)
TIMEOUT_CYCLES, 4000000, clk cycles allowed from start to done
RST_CYCLES, 16, cam_reset pulse width in clk cycles (>=1)
GAP_CYCLES, 8, idle clk cycles after any capture ends before the next start (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  global scheduler enable
cam_enable  in  2  per-camera enable, bit i = cam i
sw_trigger  in  2  one-cycle software capture request per camera
period0  in  16  cam0 periodic interval in ticks; 0 = periodic off
period1  in  16  cam1 periodic interval in ticks; 0 = periodic off
fifo_afull  in  2  per-camera FIFO almost-full, holds off starts
frame_capture_done  in  2  one-cycle done pulse from each stonyman controller
clear_err  in  1  one-cycle pulse, clears the sticky error flags
frame_capture_start  out  2  one-cycle start pulse to each stonyman controller
cam_reset  out  2  per-camera reset to the datapath (active high)
busy  out  1  high in every state other than IDLE
active_cam  out  1  index of the camera currently or last served
pending  out  2  pending request flags
overrun  out  2  sticky: trigger arrived while a request was already pending
timeout_err  out  2  sticky: capture timed out
frame_count0  out  16  completed cam0 frames, wraps at 0xFFFF->0
frame_count1  out  16  completed cam1 frames, wraps at 0xFFFF->0

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; all counters 0; round-robin pointer points to cam0 first.
- Prescaler:
  - Free-running 0..PRESCALE-1.
  - tick = 1 for one cycle when it wraps.
- Period counters (per cam i, only when enable & cam_enable[i] & period_i != 0):
  - Increment on tick.
  - When the counter reaches period_i-1 on a tick, it reloads 0 and raises a periodic request.
  - Otherwise the counter is held at 0.
- Trigger sources:
  - req_i = (sw_trigger[i] | periodic_i) & enable & cam_enable[i].
- Pending flags:
  - req_i sets pending[i].
  - req_i while pending[i] is already 1 sets overrun[i]. The exception is the cycle in which pending[i] is being cleared by START for cam i: there pending stays 1 and no overrun is flagged.
  - cam_enable[i]=0 or enable=0 clears pending[i] the same cycle.
- Eligibility: elig[i] = pending[i] & ~fifo_afull[i].
- FSM states:
  - IDLE: if any elig, choose a camera:
    - Only one eligible: choose it.
    - Both eligible: choose the camera not last served.
    - Latch the choice into active_cam and go to START.
  - START: frame_capture_start[active_cam]=1 for exactly this cycle; clear pending[active_cam]; zero the timeout counter; go to WAIT.
  - WAIT: increment the timeout counter.
    - frame_capture_done[active_cam]: increment frame_count for that cam, go to GAP.
    - Else if counter == TIMEOUT_CYCLES-1: set timeout_err[active_cam], go to RESET.
    - done on the other camera's bit is ignored.
    - done and timeout in the same cycle: done wins.
  - RESET: cam_reset[active_cam]=1 for RST_CYCLES cycles, then go to GAP. No frame count increment.
  - GAP: wait GAP_CYCLES cycles, then go to IDLE.
- Start latency: IDLE->START->WAIT, so start is asserted 2 cycles after the pending/elig condition is visible in IDLE.
- Back-to-back start spacing: at least GAP_CYCLES+3 cycles.
- Disable mid-operation: enable or cam_enable deasserted while in START, WAIT, RESET or GAP does not abort the capture; the FSM completes normally. It only blocks new requests.
- clear_err zeroes overrun and timeout_err. Error set and clear in the same cycle: set wins.
- reset_n low at any time: immediately return to the reset values, including deasserting cam_reset and start.

Test Plan:
- sw_trigger=2'b01, done on cam0 after 50 cycles:
  - frame_capture_start=01 for 1 cycle, exactly 2 cycles after the trigger.
  - busy high; frame_count0=1; FSM back in IDLE GAP_CYCLES after done.
- sw_trigger=2'b11 in the same cycle, each done after 20 cycles:
  - cam0 served first, then cam1.
  - Repeat the pair: round-robin order is still cam0 then cam1, because cam1 was served last.
- PRESCALE=4, period0=3, cam_enable=01:
  - Periodic start every 12 cycles, given done returns quickly.
  - A second sw_trigger while pending[0]=1 sets overrun[0]=1.
  - clear_err clears it.
- TIMEOUT_CYCLES=100, no done:
  - timeout_err[0]=1 at cycle 100 after start.
  - cam_reset[0] high exactly 16 cycles; frame_count0 unchanged.
  - Then the next pending request is served.
- fifo_afull=01 with both pending:
  - cam1 started, cam0 held.
  - fifo_afull falls: cam0 started after GAP.
- reset_n asserted during WAIT and during RESET:
  - All outputs 0 in the same cycle.
  - After release, the FSM is in IDLE with pending=0.
